// File: rtl/pp_bank_buffer_pkg.sv
// ============================================================================
// pp_buffer_pkg : shared defaults and width helpers for the bank buffer
// Rev 1.0
// ============================================================================
`default_nettype none

package pp_buffer_pkg;

  localparam int DEF_BIT_LENGTH = 64;
  localparam int DEF_DEPTH      = 16;
  localparam int DEF_NUM_BANKS  = 2;

  // Address width; a single-entry space still needs one bit to form a port.
  function automatic int calc_aw(input int entries);
    return (entries > 1) ? $clog2(entries) : 1;
  endfunction

  function automatic int calc_bw(input int num_banks);
    return (num_banks > 1) ? $clog2(num_banks) : 1;
  endfunction

  function automatic int calc_cw(input int num_banks);
    return $clog2(num_banks + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pp_bank_buffer_if.sv
// ============================================================================
// pp_bank_buffer_if : writer/reader bus for the rotating bank buffer
// Rev 1.0
// ============================================================================
`default_nettype none

interface pp_bank_buffer_if
  import pp_buffer_pkg::*;
#(
  parameter int BIT_LENGTH = DEF_BIT_LENGTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int NUM_BANKS  = DEF_NUM_BANKS
);
  localparam int AW = calc_aw(DEPTH);
  localparam int BW = calc_bw(NUM_BANKS);
  localparam int CW = calc_cw(NUM_BANKS);

  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [BIT_LENGTH-1:0] wr_data;
  logic                  wr_commit;
  logic                  wr_bank_ready;
  logic                  wr_drop;
  logic                  rd_en;
  logic [AW-1:0]         rd_addr;
  logic [BIT_LENGTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  rd_release;
  logic                  rd_bank_ready;
  logic [CW-1:0]         occupancy;
  logic [BW-1:0]         wr_bank;
  logic [BW-1:0]         rd_bank;

  modport master (
    output wr_en, wr_addr, wr_data, wr_commit, rd_en, rd_addr, rd_release,
    input  wr_bank_ready, wr_drop, rd_data, rd_valid, rd_bank_ready,
           occupancy, wr_bank, rd_bank
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_commit, rd_en, rd_addr, rd_release,
    output wr_bank_ready, wr_drop, rd_data, rd_valid, rd_bank_ready,
           occupancy, wr_bank, rd_bank
  );

endinterface

`default_nettype wire

// File: rtl/pp_bank_buffer_sdp_ram.sv
// ============================================================================
// sdp_ram : simple dual-port RAM, one write port, one registered read port
// Rev 1.0
// ============================================================================
`default_nettype none

module sdp_ram #(
  parameter int WIDTH   = 64,
  parameter int ENTRIES = 32,
  parameter int AW      = 5
) (
  input  logic             clk,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem_q [ENTRIES];
  logic [WIDTH-1:0] rd_q;

  // No reset on the array or read register so the tools map this onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    if (rd_en_i) begin
      rd_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_q;

endmodule

`default_nettype wire

// File: rtl/pp_bank_buffer.sv
// ============================================================================
// pp_bank_buffer : N-bank rotating buffer with commit/release bank handoff
// Rev 1.0
// ============================================================================
`default_nettype none

module pp_bank_buffer
  import pp_buffer_pkg::*;
#(
  parameter int BIT_LENGTH = DEF_BIT_LENGTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int NUM_BANKS  = DEF_NUM_BANKS
) (
  input  logic              clk,
  input  logic              rst,
  pp_bank_buffer_if.slave   bus
);

  localparam int AW  = calc_aw(DEPTH);
  localparam int BW  = calc_bw(NUM_BANKS);
  localparam int CW  = calc_cw(NUM_BANKS);
  localparam int RAW = calc_aw(NUM_BANKS * DEPTH);

  logic [BW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [BW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         occ_q, occ_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  wr_drop_q, wr_drop_d;
  logic                  rd_seen_q, rd_seen_d;

  logic                  w_wr_ready;
  logic                  w_rd_ready;
  logic                  w_commit;
  logic                  w_release;
  logic                  w_ram_we;
  logic [RAW-1:0]        w_wr_ram_addr;
  logic [RAW-1:0]        w_rd_ram_addr;
  logic [BIT_LENGTH-1:0] w_ram_rd_data;

  function automatic logic [BW-1:0] f_advance(input logic [BW-1:0] ptr);
    return (ptr == BW'(NUM_BANKS - 1)) ? '0 : ptr + BW'(1);
  endfunction

  assign w_wr_ready = (occ_q != CW'(NUM_BANKS));
  assign w_rd_ready = (occ_q != '0);
  assign w_commit   = bus.wr_commit  & w_wr_ready;
  assign w_release  = bus.rd_release & w_rd_ready;
  assign w_ram_we   = bus.wr_en      & w_wr_ready;

  // Addresses use the current (pre-advance) pointers, so a write or read in
  // the same cycle as commit/release still lands in the outgoing bank.
  assign w_wr_ram_addr = RAW'(wr_ptr_q) * RAW'(DEPTH) + RAW'(bus.wr_addr);
  assign w_rd_ram_addr = RAW'(rd_ptr_q) * RAW'(DEPTH) + RAW'(bus.rd_addr);

  always_comb begin
    wr_ptr_d   = w_commit  ? f_advance(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d   = w_release ? f_advance(rd_ptr_q) : rd_ptr_q;
    occ_d      = occ_q;
    unique case ({w_commit, w_release})
      2'b10:   occ_d = occ_q + CW'(1);
      2'b01:   occ_d = occ_q - CW'(1);
      default: occ_d = occ_q;
    endcase
    rd_valid_d = bus.rd_en & w_rd_ready;
    wr_drop_d  = (bus.wr_en | bus.wr_commit) & ~w_wr_ready;
    rd_seen_d  = rd_seen_q | bus.rd_en;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      rd_valid_q <= 1'b0;
      wr_drop_q  <= 1'b0;
      rd_seen_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      rd_valid_q <= rd_valid_d;
      wr_drop_q  <= wr_drop_d;
      rd_seen_q  <= rd_seen_d;
    end
  end

  sdp_ram #(
    .WIDTH   (BIT_LENGTH),
    .ENTRIES (NUM_BANKS * DEPTH),
    .AW      (RAW)
  ) u_ram (
    .clk       (clk),
    .wr_en_i   (w_ram_we),
    .wr_addr_i (w_wr_ram_addr),
    .wr_data_i (bus.wr_data),
    .rd_en_i   (bus.rd_en),
    .rd_addr_i (w_rd_ram_addr),
    .rd_data_o (w_ram_rd_data)
  );

  // The RAM read register has no reset; mask it to zero until the first
  // read after reset so rd_data still presents its reset value.
  assign bus.rd_data       = rd_seen_q ? w_ram_rd_data : '0;
  assign bus.rd_valid      = rd_valid_q;
  assign bus.wr_drop       = wr_drop_q;
  assign bus.wr_bank_ready = w_wr_ready;
  assign bus.rd_bank_ready = w_rd_ready;
  assign bus.occupancy     = occ_q;
  assign bus.wr_bank       = wr_ptr_q;
  assign bus.rd_bank       = rd_ptr_q;

endmodule

`default_nettype wire

// File: tb/tb_pp_bank_buffer.sv
// ============================================================================
// tb_pp_bank_buffer : directed self-checking bench, 2-bank and 3-bank builds
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pp_bank_buffer;

  logic clk;
  logic rst;

  int n_tests = 0;
  int n_fail  = 0;

  pp_bank_buffer_if #(.BIT_LENGTH(64), .DEPTH(16), .NUM_BANKS(2)) bus2 ();
  pp_bank_buffer_if #(.BIT_LENGTH(64), .DEPTH(16), .NUM_BANKS(3)) bus3 ();

  pp_bank_buffer #(.BIT_LENGTH(64), .DEPTH(16), .NUM_BANKS(2)) u_dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  pp_bank_buffer #(.BIT_LENGTH(64), .DEPTH(16), .NUM_BANKS(3)) u_dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] pattern(input int seq, input int cnt);
    return (64'(seq) << 32) | (64'hC000 + 64'(cnt));
  endfunction

  task automatic idle3();
    bus3.wr_en = 1'b0; bus3.wr_commit = 1'b0; bus3.rd_en = 1'b0; bus3.rd_release = 1'b0;
  endtask

  initial begin
    int wseq, wcnt, rseq, rcnt, drops;
    logic        rd_go;
    logic [63:0] nexp;

    rst = 1'b1;
    bus2.wr_en = 0; bus2.wr_addr = '0; bus2.wr_data = '0; bus2.wr_commit = 0;
    bus2.rd_en = 0; bus2.rd_addr = '0; bus2.rd_release = 0;
    bus3.wr_en = 0; bus3.wr_addr = '0; bus3.wr_data = '0; bus3.wr_commit = 0;
    bus3.rd_en = 0; bus3.rd_addr = '0; bus3.rd_release = 0;
    step();
    step();
    rst = 1'b0;

    check("rst_wr_ready2", 64'(bus2.wr_bank_ready), 64'd1);
    check("rst_rd_ready2", 64'(bus2.rd_bank_ready), 64'd0);
    check("rst_occ2",      64'(bus2.occupancy),     64'd0);
    check("rst_rd_valid2", 64'(bus2.rd_valid),      64'd0);
    check("rst_rd_data2",  bus2.rd_data,            64'd0);
    check("rst_wr_ready3", 64'(bus3.wr_bank_ready), 64'd1);
    check("rst_rd_ready3", 64'(bus3.rd_bank_ready), 64'd0);
    check("rst_banks3",    {62'd0, bus3.wr_bank},   64'd0);
    check("rst_wr_drop3",  64'(bus3.wr_drop),       64'd0);

    // Two banks: fill bank 0, last write shares the cycle with commit.
    for (int a = 0; a < 16; a++) begin
      bus2.wr_en = 1'b1; bus2.wr_addr = 4'(a); bus2.wr_data = 64'h100 + 64'(a);
      bus2.wr_commit = (a == 15);
      step();
    end
    bus2.wr_en = 1'b0; bus2.wr_commit = 1'b0;
    check("a_occ",      64'(bus2.occupancy),     64'd1);
    check("a_rd_ready", 64'(bus2.rd_bank_ready), 64'd1);
    check("a_wr_bank",  64'(bus2.wr_bank),       64'd1);
    for (int a = 0; a < 16; a++) begin
      bus2.rd_en = 1'b1; bus2.rd_addr = 4'(a);
      step();
      check("a_rd_data",  bus2.rd_data,        64'h100 + 64'(a));
      check("a_rd_valid", 64'(bus2.rd_valid),  64'd1);
    end
    bus2.rd_en = 1'b0;
    step();
    check("a_valid_drop", 64'(bus2.rd_valid), 64'd0);
    check("a_data_hold",  bus2.rd_data,        64'h10F);

    // Three banks: fill all three, then hit the full condition.
    for (int b = 0; b < 3; b++) begin
      bus3.wr_en = 1'b1; bus3.wr_addr = '0; bus3.wr_data = 64'hA0 + 64'(b);
      bus3.wr_commit = 1'b1;
      step();
      check("b_occ_fill", 64'(bus3.occupancy), 64'(b + 1));
    end
    idle3();
    check("b_full_wr_ready", 64'(bus3.wr_bank_ready), 64'd0);
    check("b_full_wr_bank",  64'(bus3.wr_bank),       64'd0);
    bus3.wr_en = 1'b1; bus3.wr_addr = '0; bus3.wr_data = 64'hDEAD;
    step();
    bus3.wr_en = 1'b0;
    check("b_drop_pulse", 64'(bus3.wr_drop), 64'd1);
    bus3.rd_en = 1'b1; bus3.rd_addr = '0;
    step();
    bus3.rd_en = 1'b0;
    check("b_drop_once",   64'(bus3.wr_drop), 64'd0);
    check("b_ram_intact",  bus3.rd_data,      64'hA0);
    bus3.rd_release = 1'b1;
    step();
    bus3.rd_release = 1'b0;
    check("b_rel_wr_ready", 64'(bus3.wr_bank_ready), 64'd1);
    check("b_rel_wr_bank",  64'(bus3.wr_bank),       64'd0);
    check("b_rel_rd_bank",  64'(bus3.rd_bank),       64'd1);
    check("b_rel_occ",      64'(bus3.occupancy),     64'd2);
    bus3.rd_en = 1'b1; bus3.rd_addr = '0;
    step();
    bus3.rd_en = 1'b0;
    check("b_rd_bank1", bus3.rd_data, 64'hA1);

    // Simultaneous commit and release at occupancy 1, then release while empty.
    bus3.rd_release = 1'b1;
    step();
    check("c_occ_pre", 64'(bus3.occupancy), 64'd1);
    bus3.wr_commit = 1'b1;
    step();
    idle3();
    check("c_occ_same",  64'(bus3.occupancy), 64'd1);
    check("c_wr_bank",   64'(bus3.wr_bank),   64'd1);
    check("c_rd_bank",   64'(bus3.rd_bank),   64'd0);
    bus3.rd_release = 1'b1;
    step();
    check("c_occ_empty", 64'(bus3.occupancy), 64'd0);
    step();
    bus3.rd_release = 1'b0;
    check("c_empty_rel_occ",  64'(bus3.occupancy), 64'd0);
    check("c_empty_rel_bank", 64'(bus3.rd_bank),   64'd1);

    // Streaming over 10 rotations of 3 banks.
    wseq = 0; wcnt = 0; rseq = 0; rcnt = 0; drops = 0;
    for (int cyc = 0; cyc < 2000 && rseq < 30; cyc++) begin
      idle3();
      rd_go = 1'b0;
      nexp  = '0;
      if (bus3.wr_bank_ready && wseq < 30) begin
        bus3.wr_en = 1'b1; bus3.wr_addr = 4'(wcnt); bus3.wr_data = pattern(wseq, wcnt);
        bus3.wr_commit = (wcnt == 15);
        wcnt++;
        if (wcnt == 16) begin wcnt = 0; wseq++; end
      end
      if (bus3.rd_bank_ready && rseq < 30) begin
        bus3.rd_en = 1'b1; bus3.rd_addr = 4'(rcnt);
        bus3.rd_release = (rcnt == 15);
        nexp  = pattern(rseq, rcnt);
        rd_go = 1'b1;
        rcnt++;
        if (rcnt == 16) begin rcnt = 0; rseq++; end
      end
      step();
      if (bus3.wr_drop) drops++;
      if (rd_go) check("e_stream_rd", bus3.rd_data, nexp);
    end
    idle3();
    check("e_stream_done",  64'(rseq),  64'd30);
    check("e_stream_drops", 64'(drops), 64'd0);

    // Reset with two committed banks and a read in flight.
    bus3.wr_commit = 1'b1;
    step();
    step();
    bus3.wr_commit = 1'b0;
    check("d_occ_pre", 64'(bus3.occupancy), 64'd2);
    bus3.rd_en = 1'b1; bus3.rd_addr = '0;
    step();
    bus3.rd_en = 1'b0;
    check("d_valid_pre", 64'(bus3.rd_valid), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("d_occ",      64'(bus3.occupancy),     64'd0);
    check("d_wr_bank",  64'(bus3.wr_bank),       64'd0);
    check("d_rd_bank",  64'(bus3.rd_bank),       64'd0);
    check("d_rd_valid", 64'(bus3.rd_valid),      64'd0);
    check("d_rd_data",  bus3.rd_data,            64'd0);
    check("d_wr_ready", 64'(bus3.wr_bank_ready), 64'd1);
    check("d_rd_ready", 64'(bus3.rd_bank_ready), 64'd0);
    bus3.wr_en = 1'b1; bus3.wr_addr = 4'd3; bus3.wr_data = 64'h55; bus3.wr_commit = 1'b1;
    step();
    idle3();
    check("d_post_occ", 64'(bus3.occupancy), 64'd1);
    bus3.rd_en = 1'b1; bus3.rd_addr = 4'd3;
    step();
    bus3.rd_en = 1'b0;
    check("d_post_data",  bus3.rd_data,       64'h55);
    check("d_post_valid", 64'(bus3.rd_valid), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pp_bank_buffer.md
# pp_bank_buffer

Parametrised N-bank rotating buffer generalising the two-bank ping-pong scheme. The writer fills one bank while the reader drains another, with explicit commit/release handshakes, occupancy tracking and back-pressure. It sits between a producing layer engine and a consuming one in the NN datapath, replacing hard-wired ping/pong select with self-managed bank pointers.

## Interface
- BIT_LENGTH, 64, data word width
- DEPTH, 16, words per bank; address width AW = $clog2(DEPTH); addresses ≥ DEPTH are invalid (do not drive)
- NUM_BANKS, 2, bank count, ≥ 2, non-power-of-two allowed; BW = $clog2(NUM_BANKS), CW = $clog2(NUM_BANKS+1)

- clk  input  1  single clock, all logic on posedge
- rst  input  1  synchronous active-high reset
- wr_en  input  1  write wr_data to wr_addr of the current write bank
- wr_addr  input  AW  word address within the write bank
- wr_data  input  BIT_LENGTH  write data
- wr_commit  input  1  current write bank complete; hand it to the reader
- wr_bank_ready  output  1  a bank is owned by the writer (occupancy < NUM_BANKS)
- wr_drop  output  1  registered one-cycle pulse: wr_en or wr_commit arrived while wr_bank_ready = 0
- rd_en  input  1  read rd_addr of the current read bank
- rd_addr  input  AW  word address within the read bank
- rd_data  output  BIT_LENGTH  read data, registered
- rd_valid  output  1  rd_data holds a qualified read result
- rd_release  input  1  current read bank consumed; return it to the writer
- rd_bank_ready  output  1  at least one committed bank is available (occupancy > 0)
- occupancy  output  CW  number of committed, unreleased banks
- wr_bank, rd_bank  output  BW  current bank indices (debug/observability)

## Operation
- State: wr_ptr, rd_ptr (0..NUM_BANKS-1), occ (0..NUM_BANKS); all registered.
- wr_bank_ready = (occ != NUM_BANKS); rd_bank_ready = (occ != 0); combinational from registers.
- Write: wr_en & wr_bank_ready → RAM[wr_ptr*DEPTH + wr_addr] <= wr_data. Otherwise no write.
- Commit: wr_commit & wr_bank_ready → wr_ptr advances (NUM_BANKS-1 wraps to 0), occ+1.
- Read: rd_en → RAM[rd_ptr*DEPTH + rd_addr] captured into rd_data; rd_valid <= rd_en & rd_bank_ready. rd_data updates only on rd_en; otherwise it holds.
- Release: rd_release & rd_bank_ready → rd_ptr advances with wrap, occ−1. Release while empty is ignored, no flag.
- Simultaneous commit and release (both legal): both pointers advance, occ unchanged.
- Write/read in the same cycle as commit/release use the pre-advance bank.
- wr_drop <= (wr_en | wr_commit) & ~wr_bank_ready.
- Legal operation never reads and writes the same bank: occ = 0 gates the reader and occ = NUM_BANKS gates the writer. No bypass logic is required.
- Reset mid-operation: pointers and occupancy clear, and all banks return to the writer. RAM contents are not cleared; any data in flight is abandoned.

## Timing
- Reset values: wr_ptr = rd_ptr = 0, occ = 0, rd_data = 0, rd_valid = 0, wr_drop = 0. Hence wr_bank_ready = 1, rd_bank_ready = 0, wr_bank = rd_bank = 0.
- Read latency: 1 cycle. rd_en at edge N → rd_data/rd_valid valid after edge N+1.
- Commit-to-read: commit at edge N → rd_bank_ready = 1 after edge N+1, when previously empty. Data written at edge N is readable from edge N+1.
- Release-to-write: release at edge N frees a bank for writes from edge N+1.
- Sustained throughput: one write and one read per cycle, no bubbles at bank swap.

## Structure
- Package pp_buffer_pkg holds the width helper constants/functions (AW, BW, CW derivations) and the default parameter values shared with the producer/consumer engines.
- One sub-module, sdp_ram: simple dual-port RAM (NUM_BANKS*DEPTH × BIT_LENGTH), one write port and one registered read port with enable. It has no reset on the array and infers block RAM. The rd_data reset is applied in the wrapper register.
- The control block (pointers, occupancy, flags) lives in pp_bank_buffer.

## Test plan
- Reset, then idle → wr_bank_ready = 1, rd_bank_ready = 0, occupancy = 0, rd_valid = 0, rd_data = 0.
- NUM_BANKS = 2, DEPTH = 16: write 0..15 with data = addr+0x100, commit, then read addr 0..15 → rd_data = 0x100..0x10F one cycle after each rd_en, rd_valid high; occupancy = 1.
- NUM_BANKS = 3: commit three banks with no release → occupancy = 3, wr_bank_ready = 0. A further wr_en → wr_drop pulses once and RAM is unchanged. Release → wr_bank_ready = 1 next cycle, wr_bank = 0 (wrap).
- Same-cycle commit + release with occupancy = 1 → occupancy stays 1; wr_bank and rd_bank each advance by 1.
- Streaming: continuous writes/reads over 10 bank rotations with NUM_BANKS = 3 → every read word matches the scoreboard; zero wr_drop.
- rst asserted with occupancy = 2 → next cycle occupancy = 0, pointers = 0, rd_valid = 0; a subsequent fill/commit/read behaves as after power-up.
